// File: rtl/seq_divider16_if.sv
// Handshake and result bundle for the sequential restoring divider.
interface seq_divider16_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Requester side drives operands and start, observes results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/seq_divider16.sv
// Unsigned restoring divider, one quotient bit per clock.
// IDLE accepts a request, RUN iterates WIDTH times, DONE pulses for one cycle.
// A zero divisor skips RUN and reports all-ones quotient with div_zero set.
module seq_divider16 #(
    parameter int unsigned WIDTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    seq_divider16_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    // Shift keeps the old remainder MSB, so the trial is WIDTH+1 bits and the borrow is its MSB.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction for the current restoring step.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    // Control FSM together with the datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        dvs_q <= bus.divisor;
                        if (bus.divisor == '0) begin
                            quo_q   <= '1;
                            rem_q   <= bus.dividend;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= bus.dividend;
                            cnt_q   <= CntW'(WIDTH);
                            dz_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (trial[WIDTH]) begin
                        // Borrow: restore; shifted MSB is zero here since shifted < divisor.
                        rem_q <= shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = dz_q;
endmodule
